// File: rtl/axil_wb_pkg.sv
// Shared types for the AXI-lite read to Wishbone bridge: response codes and
// the abort/flush state encoding.
package axil_wb_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

endpackage

// File: rtl/sfifo_resp.sv
// Response FIFO: array storage with a registered read port feeding a
// first-word-fall-through output register. o_fill counts the output register too.
module sfifo_resp #(
  parameter int WIDTH = 34,
  parameter int LG    = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_ready,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [LG:0]      o_fill
);

  localparam int DEPTH = 1 << LG;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LG:0]      wr_ptr_reg;
  logic [LG:0]      rd_ptr_reg;
  logic [LG:0]      mem_cnt;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             load;

  assign mem_cnt = wr_ptr_reg - rd_ptr_reg;
  // Refill the output register whenever it is empty or being consumed.
  assign load    = (mem_cnt != '0) && (!out_valid_reg || i_rd_ready);

  always_ff @(posedge i_clk) begin
    if (i_wr)
      mem[wr_ptr_reg[LG-1:0]] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      if (i_wr)
        wr_ptr_reg <= wr_ptr_reg + (LG+1)'(1);
      if (load) begin
        rd_ptr_reg    <= rd_ptr_reg + (LG+1)'(1);
        out_data_reg  <= mem[rd_ptr_reg[LG-1:0]];
        out_valid_reg <= 1'b1;
      end else if (i_rd_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign o_rd_valid = out_valid_reg;
  assign o_rd_data  = out_data_reg;
  assign o_fill     = mem_cnt + {{LG{1'b0}}, out_valid_reg};

endmodule

// File: rtl/axil_rdq_wb_bridge.sv
// Pipelined AXI4-lite read channel to pipelined Wishbone bridge with in-order
// response buffering, error flush and optional bus watchdog.
module axil_rdq_wb_bridge
  import axil_wb_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int LGFIFO           = 3,
  parameter int LGTIMEOUT        = 0,
  localparam int DW = C_AXI_DATA_WIDTH,
  localparam int AW = C_AXI_ADDR_WIDTH - $clog2(C_AXI_DATA_WIDTH/8)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_axi_arvalid,
  output logic            o_axi_arready,
  input  logic [AW-1:0]   i_axi_araddr,
  input  logic [2:0]      i_axi_arprot,
  output logic            o_axi_rvalid,
  input  logic            i_axi_rready,
  output logic [DW-1:0]   o_axi_rdata,
  output logic [1:0]      o_axi_rresp,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic [DW-1:0]   i_wb_data,
  input  logic            i_wb_err
);

  localparam int DEPTH = 1 << LGFIFO;
  localparam int WDW   = (LGTIMEOUT > 0) ? LGTIMEOUT : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'((1 << LGTIMEOUT) - 1);

  state_t          state_reg, state_next;
  logic [LGFIFO:0] n_out_reg, n_out_next;
  logic            stb_reg, stb_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [WDW-1:0]  wd_reg, wd_next;

  logic [LGFIFO:0] fill;
  logic            credit, ar_hs, cyc, bus_err, wd_expire;
  logic            push;
  logic [DW+1:0]   push_data;
  logic [DW+1:0]   rd_word;
  logic            unused_prot;

  assign unused_prot = &{1'b0, i_axi_arprot};

  // Outstanding reads plus buffered responses never exceed the FIFO depth,
  // so every response always has a slot waiting for it.
  assign credit = ({1'b0, n_out_reg} + {1'b0, fill}) < (LGFIFO+2)'(DEPTH);
  assign o_axi_arready = !i_reset && (state_reg == ST_RUN) && credit
                         && (!stb_reg || !i_wb_stall);
  assign ar_hs     = i_axi_arvalid && o_axi_arready;
  assign cyc       = (state_reg == ST_RUN) && (stb_reg || (n_out_reg != '0));
  assign bus_err   = cyc && i_wb_err;
  assign wd_expire = (LGTIMEOUT != 0) && cyc && !i_wb_ack && !i_wb_err
                     && (wd_reg == WD_MAX);

  always_comb begin
    state_next = state_reg;
    n_out_next = n_out_reg;
    stb_next   = stb_reg;
    addr_next  = addr_reg;
    push       = 1'b0;
    push_data  = {RESP_OKAY, i_wb_data};

    if (!cyc || i_wb_ack || i_wb_err)
      wd_next = '0;
    else
      wd_next = wd_reg + WDW'(1);

    case (state_reg)
      ST_RUN: begin
        if (ar_hs) begin
          stb_next  = 1'b1;
          addr_next = i_axi_araddr;
        end else if (!i_wb_stall) begin
          stb_next = 1'b0;
        end
        // An ack coincident with the error is answered by the flush instead.
        if (bus_err || wd_expire) begin
          state_next = ST_FLUSH;
          stb_next   = 1'b0;
        end else if (cyc && i_wb_ack) begin
          push = 1'b1;
        end
        n_out_next = n_out_reg + (LGFIFO+1)'(ar_hs) - (LGFIFO+1)'(push);
      end
      ST_FLUSH: begin
        stb_next = 1'b0;
        if (n_out_reg == '0) begin
          state_next = ST_RUN;
        end else if (fill < (LGFIFO+1)'(DEPTH)) begin
          push       = 1'b1;
          push_data  = {RESP_SLVERR, {DW{1'b0}}};
          n_out_next = n_out_reg - (LGFIFO+1)'(1);
          if (n_out_reg == (LGFIFO+1)'(1))
            state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= ST_RUN;
      n_out_reg <= '0;
      stb_reg   <= 1'b0;
      addr_reg  <= '0;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      n_out_reg <= n_out_next;
      stb_reg   <= stb_next;
      addr_reg  <= addr_next;
      wd_reg    <= wd_next;
    end
  end

  sfifo_resp #(
    .WIDTH (DW + 2),
    .LG    (LGFIFO)
  ) u_resp_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr       (push),
    .i_wr_data  (push_data),
    .i_rd_ready (i_axi_rready),
    .o_rd_valid (o_axi_rvalid),
    .o_rd_data  (rd_word),
    .o_fill     (fill)
  );

  assign o_axi_rresp = rd_word[DW+1:DW];
  assign o_axi_rdata = rd_word[DW-1:0];
  assign o_wb_cyc    = cyc;
  assign o_wb_stb    = stb_reg;
  assign o_wb_addr   = addr_reg;
  assign o_wb_sel    = '1;

endmodule
